// File: rtl/wshb_stream_sink_if.sv
// -----------------------------------------------------------------------------
// wshb_stream_sink_if
//   Wishbone classic bus bundle between the hw_support pixel-stream master and
//   the wshb_stream_sink slave.
//
//   Signals:
//     wb_cyc, wb_stb, wb_we   cycle / strobe / write enable    (master -> slave)
//     wb_adr[ADR_W]           byte address                     (master -> slave)
//     wb_dat_ms[32]           write data                       (master -> slave)
//     wb_sel[4]               byte selects                     (master -> slave)
//     wb_ack, wb_err, wb_rty  termination                      (slave -> master)
//     wb_dat_sm[32]           read data                        (slave -> master)
// -----------------------------------------------------------------------------
interface wshb_stream_sink_if #(
  parameter int ADR_W = 32
);
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [ADR_W-1:0] wb_adr;
  logic [31:0]      wb_dat_ms;
  logic [3:0]       wb_sel;
  logic             wb_ack;
  logic             wb_err;
  logic             wb_rty;
  logic [31:0]      wb_dat_sm;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
    input  wb_ack, wb_err, wb_rty, wb_dat_sm
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
    output wb_ack, wb_err, wb_rty, wb_dat_sm
  );
endinterface

// File: rtl/wshb_stream_sink.sv
// -----------------------------------------------------------------------------
// wshb_stream_sink
//   Wishbone classic slave terminating the hw_support pixel-stream bus.
//   Write cycles are acknowledged one cycle after the request and pushed,
//   byte-masked by wb_sel, into a first-word-fall-through FIFO together with
//   a start-of-frame flag (address == SOF_ADR). When the FIFO is full the ack
//   is withheld, which stalls the master. Read cycles are terminated with a
//   one-cycle wb_err and never push.
//
//   Ports:
//     sys_clk, sys_rst_n   clock, asynchronous active-low reset
//     wb                   Wishbone slave modport (see wshb_stream_sink_if)
//     out_valid/out_ready  stream handshake, head popped when both are high
//     out_data, out_sof    FIFO head (masked data, start-of-frame flag)
//     fifo_level           current occupancy, 0..FIFO_DEPTH
//
//   Optional build macro WSHB_STREAM_SINK_STATS_EN adds wrapping counters:
//     stat_words (acked writes), stat_frames (acked writes at SOF_ADR),
//     stat_errs (err pulses).
// -----------------------------------------------------------------------------
module wshb_stream_sink #(
  parameter int                 FIFO_DEPTH = 16,
  parameter int                 ADR_W      = 32,
  parameter logic [ADR_W-1:0]   SOF_ADR    = {ADR_W{1'b0}}
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  wshb_stream_sink_if.slave             wb,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_sof,
`ifdef WSHB_STREAM_SINK_STATS_EN
  output logic [31:0]                   stat_words,
  output logic [15:0]                   stat_frames,
  output logic [15:0]                   stat_errs,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Zero every byte lane whose select is low.
  function automatic logic [31:0] sel_mask(input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = dat[8*i +: 8];
      end else begin
        res[8*i +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  // Entry layout: bit 32 = start-of-frame flag, bits 31:0 = masked data.
  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             ack_q,    ack_d;
  logic             err_q,    err_d;

  logic             req_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [32:0]      push_word_s;
  logic [32:0]      head_s;

`ifdef WSHB_STREAM_SINK_STATS_EN
  logic [31:0] stat_words_q,  stat_words_d;
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_errs_q,   stat_errs_d;
`endif

  // Request decode, handshake and FIFO pointer/level next-state.
  always_comb begin
    // A pending ack/err masks the request, so a held strobe can never be
    // acknowledged on two consecutive cycles.
    req_s       = wb.wb_cyc & wb.wb_stb & ~ack_q & ~err_q;
    // Full uses the registered level: a same-cycle pop does not make room.
    full_s      = (level_q == LVL_FULL);
    push_s      = req_s & wb.wb_we & ~full_s;
    pop_s       = (level_q != LVL_ZERO) & out_ready;
    ack_d       = push_s;
    err_d       = req_s & ~wb.wb_we;
    push_word_s = {(wb.wb_adr == SOF_ADR), sel_mask(wb.wb_dat_ms, wb.wb_sel)};

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

`ifdef WSHB_STREAM_SINK_STATS_EN
  // Statistics counters, free-running and wrapping.
  always_comb begin
    stat_words_d  = stat_words_q;
    stat_frames_d = stat_frames_q;
    stat_errs_d   = stat_errs_q;
    if (push_s) begin
      stat_words_d = stat_words_q + 32'd1;
      if (push_word_s[32]) begin
        stat_frames_d = stat_frames_q + 16'd1;
      end else begin
        stat_frames_d = stat_frames_q;
      end
    end else begin
      stat_words_d  = stat_words_q;
      stat_frames_d = stat_frames_q;
    end
    if (err_d) begin
      stat_errs_d = stat_errs_q + 16'd1;
    end else begin
      stat_errs_d = stat_errs_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_words_q  <= 32'd0;
      stat_frames_q <= 16'd0;
      stat_errs_q   <= 16'd0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_frames_q <= stat_frames_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_frames = stat_frames_q;
  assign stat_errs   = stat_errs_q;
`endif

  // Control state: handshake flags, pointers and occupancy.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= LVL_ZERO;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents are only observed through the level-qualified head.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  // Head is gated by out_valid so stale storage never leaks out when empty.
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_valid = (level_q != LVL_ZERO);
    if (out_valid) begin
      out_data = head_s[31:0];
      out_sof  = head_s[32];
    end else begin
      out_data = 32'h0000_0000;
      out_sof  = 1'b0;
    end
  end

  assign fifo_level   = level_q;
  assign wb.wb_ack    = ack_q;
  assign wb.wb_err    = err_q;
  assign wb.wb_rty    = 1'b0;
  assign wb.wb_dat_sm = 32'h0000_0000;

endmodule
